// File: rtl/spi_burst_master_if.sv
// Bundle of the control, word handshake and SPI pin signals of spi_burst_master.
// The master modport is the controller side; slave is the sequencer/pin side.
interface spi_burst_master_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              stop;
    logic              cpol;
    logic              cpha;
    logic [CNT_W-1:0]  word_cnt;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              start_status;
    logic              done;
    logic              start_clear;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              cs_n;

    modport master (
        input  start, stop, cpol, cpha, word_cnt, tx_data, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, start_status, done, start_clear,
               sclk, mosi, cs_n
    );

    modport slave (
        output start, stop, cpol, cpha, word_cnt, tx_data, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, start_status, done, start_clear,
               sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_burst_master.sv
// SPI burst master: one CS assertion per burst, word-counted or continuous
// until stop, with a one-entry tx holding register and gap-free word chaining.
//
// state | meaning
// IDLE  | cs_n high, sclk at latched cpol, waiting for start
// SETUP | CS setup time, CLK_DIV cycles
// WAIT  | tx underflow between words, cs_n stays low
// XFER  | shifting one word, 2*DATA_W ticks
// HOLD  | CS hold time, CLK_DIV cycles, then end pulse
module spi_burst_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    spi_burst_master_if.master bus
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, WAIT, XFER, HOLD} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] hold_reg;
    logic              hold_full;
    logic              stop_req;
    logic              cpol_l;
    logic              cpha_l;
    logic [CNT_W-1:0]  wc_l;
    logic [CNT_W-1:0]  word_count;
    logic              sclk_r;
    logic              mosi_r;
    logic              cs_n_r;
    logic [DATA_W-1:0] rx_data_r;
    logic              rx_valid_r;
    logic              done_r;
    logic              clear_r;
    logic              status_r;

    logic              tick;
    logic              leading;
    logic              word_end;
    logic              sample_now;
    logic [DATA_W-1:0] rx_next;
    logic [CNT_W-1:0]  wc_next;
    logic              stop_now;
    logic              count_end;
    logic              do_load;

    assign tick       = (div_cnt == DIV_LAST);
    assign leading    = ~edge_cnt[0];
    assign word_end   = (state == XFER) && tick && (edge_cnt == EDGE_LAST);
    // cpha=0 samples on the leading edge, cpha=1 on the trailing edge
    assign sample_now = tick && (leading ^ cpha_l);
    assign rx_next    = sample_now ? {rx_sh[DATA_W-2:0], bus.miso} : rx_sh;
    assign wc_next    = word_count + 1'b1;
    // a stop arriving exactly on a boundary cycle is honoured there too
    assign stop_now   = stop_req | bus.stop;
    assign count_end  = (wc_l != '0) && (wc_next == wc_l);
    assign do_load    = hold_full && (
                           ((state == SETUP) && tick) ||
                           ((state == WAIT) && !stop_now) ||
                           (word_end && !stop_now && !count_end));

    assign bus.tx_ready     = ~hold_full;
    assign bus.rx_data      = rx_data_r;
    assign bus.rx_valid     = rx_valid_r;
    assign bus.start_status = status_r;
    assign bus.done         = done_r;
    assign bus.start_clear  = clear_r;
    assign bus.sclk         = sclk_r;
    assign bus.mosi         = mosi_r;
    assign bus.cs_n         = cs_n_r;

    // Control automat, holding register, shifter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            hold_reg   <= '0;
            hold_full  <= 1'b0;
            stop_req   <= 1'b0;
            cpol_l     <= 1'b0;
            cpha_l     <= 1'b0;
            wc_l       <= '0;
            word_count <= '0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            cs_n_r     <= 1'b1;
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
            done_r     <= 1'b0;
            clear_r    <= 1'b0;
            status_r   <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            done_r     <= 1'b0;
            clear_r    <= 1'b0;

            if (bus.tx_valid && !hold_full) begin
                hold_reg  <= bus.tx_data;
                hold_full <= 1'b1;
            end
            if (state != IDLE && bus.stop) stop_req <= 1'b1;

            case (state)
                IDLE: begin
                    sclk_r  <= cpol_l;
                    div_cnt <= '0;
                    if (bus.start && !bus.stop) begin
                        state      <= SETUP;
                        cpol_l     <= bus.cpol;
                        cpha_l     <= bus.cpha;
                        wc_l       <= bus.word_cnt;
                        sclk_r     <= bus.cpol;
                        status_r   <= 1'b1;
                        cs_n_r     <= 1'b0;
                        word_count <= '0;
                        stop_req   <= 1'b0;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        div_cnt <= '0;
                        state   <= hold_full ? XFER : WAIT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    sclk_r  <= cpol_l;
                    div_cnt <= '0;
                    if (stop_now)       state <= HOLD;
                    else if (hold_full) state <= XFER;
                end
                XFER: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        edge_cnt <= edge_cnt + 1'b1;
                        rx_sh    <= rx_next;
                        if (leading) begin
                            sclk_r <= ~cpol_l;
                            if (cpha_l) begin
                                mosi_r <= tx_sh[DATA_W-1];
                                tx_sh  <= tx_sh << 1;
                            end
                        end else begin
                            sclk_r <= cpol_l;
                            if (!cpha_l) begin
                                mosi_r <= tx_sh[DATA_W-2];
                                tx_sh  <= tx_sh << 1;
                            end
                        end
                    end
                    if (word_end) begin
                        rx_data_r  <= rx_next;
                        rx_valid_r <= 1'b1;
                        word_count <= wc_next;
                        if (stop_now || count_end) begin
                            state   <= HOLD;
                            div_cnt <= '0;
                        end else if (!hold_full) begin
                            state   <= WAIT;
                            div_cnt <= '0;
                        end
                    end
                end
                HOLD: begin
                    sclk_r <= cpol_l;
                    if (tick) begin
                        state    <= IDLE;
                        div_cnt  <= '0;
                        cs_n_r   <= 1'b1;
                        status_r <= 1'b0;
                        stop_req <= 1'b0;
                        if (stop_now) clear_r <= 1'b1;
                        else          done_r  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // word start: shifter takes the holding register; cpha=0 presents MSB now
            if (do_load) begin
                tx_sh     <= hold_reg;
                hold_full <= 1'b0;
                edge_cnt  <= '0;
                if (!cpha_l) mosi_r <= hold_reg[DATA_W-1];
            end
        end
    end
endmodule
